vga_text_writer: RTL and testbench
==================================

VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have parameters, one per line, as name, default, meaning:
- FIFO_DEPTH, 8, character FIFO entries (power of 2)
- CMD_PUT, 8'h01, command word for the put-character operation
- CMD_CLR, 8'h02, command word for the clear-screen operation
- SETTLE_CYC, 4, wait cycles after a command write before idle polling starts
- COLS, 80, screen columns
- ROWS, 30, screen rows

REQ-002 SHALL have ports, one per line, as name, direction, width, meaning:
- clk, in, 1, single clock; all state on its rising edge
- rst, in, 1, asynchronous active-low reset
- char_valid, in, 1, character offered
- char_data, in, 7, ASCII code
- char_ready, out, 1, FIFO not full
- clear_req, in, 1, one-cycle pulse requesting a screen clear
- wea, out, 1, peripheral register write strobe
- addra, out, 4, peripheral register address
- dina, out, 32, peripheral write data
- douta, in, 32, peripheral read data, valid one cycle after addra
- cur_x, out, 7, next write column
- cur_y, out, 5, next write row
- busy, out, 1, FIFO non-empty or FSM not in IDLE

Function
REQ-003 SHALL accept a character when char_valid && char_ready and push it into the FIFO in the same cycle; char_ready SHALL be low when the FIFO holds FIFO_DEPTH entries.
REQ-004 SHALL latch clear_req into a pending flag, held until it is serviced.
REQ-005 SHALL use states IDLE, WR_CHAR, WR_X, WR_Y, WR_CMD, SETTLE, POLL_A, POLL_C.
REQ-006 In IDLE, a pending clear SHALL take priority over FIFO data and SHALL go to WR_CMD with command CMD_CLR.
REQ-007 Otherwise, in IDLE with a non-empty FIFO, the FSM SHALL pop one entry:
- code 7'h0A: no bus access; cur_x=0; cur_y increments; stay in IDLE
- any other code: go to WR_CHAR
REQ-008 WR_CHAR, WR_X and WR_Y SHALL each assert wea for exactly one cycle with:
- WR_CHAR: addra=1, dina={25'b0,code}
- WR_X: addra=2, dina={25'b0,cur_x}
- WR_Y: addra=3, dina={27'b0,cur_y}
REQ-009 WR_CMD SHALL assert wea for one cycle with addra=0, dina={24'b0,CMD_PUT or CMD_CLR}.
REQ-010 SETTLE SHALL hold wea=0 for SETTLE_CYC cycles, then go to POLL_A.
REQ-011 POLL_A SHALL drive addra=0, wea=0 for one cycle; POLL_C SHALL sample douta[0]:
- 1: update the cursor and go to IDLE
- 0: return to POLL_A
REQ-012 Cursor update after a put SHALL be:
- cur_x+1
- at cur_x=COLS-1: cur_x=0 and cur_y+1
- cur_y wraps from ROWS-1 to 0
REQ-013 Cursor update after a clear SHALL be cur_x=0, cur_y=0, and SHALL clear the pending flag.
REQ-014 A clear_req arriving during a put SHALL be serviced on the next IDLE cycle; the FIFO contents SHALL be preserved.
REQ-015 wea SHALL be low in every state other than WR_CHAR, WR_X, WR_Y and WR_CMD, and addra/dina SHALL be registered outputs.
REQ-016 A simultaneous push and pop on a full FIFO SHALL not accept the push (char_ready is low), and a simultaneous push and pop on a non-empty FIFO SHALL keep the count unchanged.

Reset
REQ-017 On rst low, the block SHALL asynchronously reset to:
- FSM=IDLE, FIFO empty, clear flag 0
- cur_x=0, cur_y=0
- wea=0, addra=0, dina=0
- busy=0, char_ready=1
REQ-018 Reset asserted mid-sequence SHALL abort the sequence with no further wea pulse; the FIFO contents SHALL be discarded.

Verification
REQ-019 Push 'A' (7'h41) with douta[0]=1: writes (1,0x41),(2,0),(3,0),(0,0x01) on four consecutive cycles -> after settle and poll, cur_x=1, busy=0.
REQ-020 Hold douta[0]=0 for 20 cycles after WR_CMD: POLL_A/POLL_C alternate with wea=0 -> no new write until douta[0]=1; cursor unchanged until then.
REQ-021 81 non-newline chars from (0,0) -> 81st written at x=0,y=1; final cur_x=1, cur_y=1; char at (79,29) -> cursor wraps to (0,0).
REQ-022 Push 'H',0x0A,'I' -> 'I' written with x=0,y=1; the newline produces no wea pulse.
REQ-023 Push 9 chars while douta[0]=0 -> char_ready low after the FIFO is full, with no data loss; clear_req mid-put -> next command written is 0x02 and the cursor becomes (0,0).
REQ-024 Drive rst low during SETTLE -> wea=0 immediately, busy=0, char_ready=1, cursor=(0,0).

Source files
------------

// File: rtl/vga_text_writer_if.sv
// Character stream, clear request and peripheral register bus of the VGA text writer.
interface vga_text_writer_if;
  logic        char_valid;
  logic [6:0]  char_data;
  logic        char_ready;
  logic        clear_req;
  logic        wea;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  // Writer side: consumes characters, drives the peripheral register bus.
  modport master (
    input  char_valid, char_data, clear_req, douta,
    output char_ready, wea, addra, dina, cur_x, cur_y, busy
  );

  // Environment side: offers characters, models the peripheral.
  modport slave (
    output char_valid, char_data, clear_req, douta,
    input  char_ready, wea, addra, dina, cur_x, cur_y, busy
  );
endinterface

// File: rtl/vga_text_writer.sv
// Buffers ASCII characters and writes them to a memory-mapped text peripheral:
// char, x, y, command, then waits for the peripheral's done bit before moving on.
module vga_text_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  CMD_PUT    = 8'h01,
  parameter logic [7:0]  CMD_CLR    = 8'h02,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30
) (
  input logic               clk,
  input logic               rst,
  vga_text_writer_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle, StWrChar, StWrX, StWrY, StWrCmd, StSettle, StPollA, StPollC
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push, pop;
  logic [6:0]      head;
  logic            clr_pend_q, clr_pend_d;
  logic            op_clr_q, op_clr_d;
  logic [6:0]      code_q, code_d;
  logic [7:0]      settle_q, settle_d;
  logic [6:0]      cur_x_q, cur_x_d;
  logic [4:0]      cur_y_q, cur_y_d;
  logic            wea_q, wea_d;
  logic [3:0]      addra_q, addra_d;
  logic [31:0]     dina_q, dina_d;
  logic [6:0]      put_x;
  logic [4:0]      put_y, nl_y;
  logic            unused_douta;

  assign unused_douta   = ^bus.douta[31:1];
  assign bus.char_ready = (count_q != CW'(FIFO_DEPTH));
  assign push           = bus.char_valid && bus.char_ready;
  assign head           = mem[rd_ptr_q];
  assign bus.busy       = (count_q != '0) || (state_q != StIdle);
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;
  assign bus.wea        = wea_q;
  assign bus.addra      = addra_q;
  assign bus.dina       = dina_q;

  // Cursor successors: after a put (with line and screen wrap) and after a newline.
  always_comb begin
    nl_y  = (cur_y_q == 5'(ROWS - 1)) ? 5'd0 : cur_y_q + 5'd1;
    put_x = cur_x_q + 7'd1;
    put_y = cur_y_q;
    if (cur_x_q == 7'(COLS - 1)) begin
      put_x = 7'd0;
      put_y = nl_y;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.char_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Next state, cursor and bus outputs; outputs are decoded from the next state so the
  // registered strobe lines up with the state that owns it.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    code_d     = code_q;
    op_clr_d   = op_clr_q;
    settle_d   = settle_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    clr_pend_d = clr_pend_q | bus.clear_req;

    unique case (state_q)
      StIdle: begin
        if (clr_pend_q) begin
          op_clr_d = 1'b1;
          state_d  = StWrCmd;
        end else if (count_q != '0) begin
          pop = 1'b1;
          if (head == 7'h0A) begin
            cur_x_d = 7'd0;
            cur_y_d = nl_y;
          end else begin
            code_d   = head;
            op_clr_d = 1'b0;
            state_d  = StWrChar;
          end
        end
      end
      StWrChar: state_d = StWrX;
      StWrX:    state_d = StWrY;
      StWrY:    state_d = StWrCmd;
      StWrCmd: begin
        settle_d = 8'd0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == 8'(SETTLE_CYC - 1)) state_d = StPollA;
        else settle_d = settle_q + 8'd1;
      end
      StPollA: state_d = StPollC;
      StPollC: begin
        if (bus.douta[0]) begin
          state_d = StIdle;
          if (op_clr_q) begin
            cur_x_d    = 7'd0;
            cur_y_d    = 5'd0;
            // a request landing in the completion cycle stays pending
            clr_pend_d = bus.clear_req;
          end else begin
            cur_x_d = put_x;
            cur_y_d = put_y;
          end
        end else begin
          state_d = StPollA;
        end
      end
      default: state_d = StIdle;
    endcase

    wea_d   = 1'b0;
    addra_d = 4'd0;
    dina_d  = 32'd0;
    unique case (state_d)
      StWrChar: begin
        wea_d   = 1'b1;
        addra_d = 4'd1;
        dina_d  = {25'b0, code_d};
      end
      StWrX: begin
        wea_d   = 1'b1;
        addra_d = 4'd2;
        dina_d  = {25'b0, cur_x_q};
      end
      StWrY: begin
        wea_d   = 1'b1;
        addra_d = 4'd3;
        dina_d  = {27'b0, cur_y_q};
      end
      StWrCmd: begin
        wea_d   = 1'b1;
        addra_d = 4'd0;
        dina_d  = {24'b0, (op_clr_d ? CMD_CLR : CMD_PUT)};
      end
      default: ;
    endcase
  end

  // Control state, cursor and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      clr_pend_q <= 1'b0;
      op_clr_q   <= 1'b0;
      code_q     <= 7'd0;
      settle_q   <= 8'd0;
      cur_x_q    <= 7'd0;
      cur_y_q    <= 5'd0;
      wea_q      <= 1'b0;
      addra_q    <= 4'd0;
      dina_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      op_clr_q   <= op_clr_d;
      code_q     <= code_d;
      settle_q   <= settle_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: expected register writes are queued when
// characters are offered and checked as the bus strobes them.
module tb_vga_text_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   done = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   mx = 0;
  int   my = 0;
  logic [35:0] exp_q [$];
  logic [35:0] mon_exp;

  always #5 clk = ~clk;

  vga_text_writer_if bus ();
  assign bus.douta = {31'b0, done};

  vga_text_writer #(
    .FIFO_DEPTH(8),
    .CMD_PUT   (8'h01),
    .CMD_CLR   (8'h02),
    .SETTLE_CYC(4),
    .COLS      (80),
    .ROWS      (30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the cursor and the writes one character produces.
  task automatic model_put(input logic [6:0] code);
    exp_q.push_back({4'd1, 25'b0, code});
    exp_q.push_back({4'd2, 25'b0, 7'(mx)});
    exp_q.push_back({4'd3, 27'b0, 5'(my)});
    exp_q.push_back({4'd0, 24'b0, 8'h01});
    if (mx == 79) begin
      mx = 0;
      my = (my == 29) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic model_nl();
    mx = 0;
    my = (my == 29) ? 0 : my + 1;
  endtask

  task automatic model_clr();
    exp_q.push_back({4'd0, 32'h2});
    mx = 0;
    my = 0;
  endtask

  task automatic push_char(input logic [6:0] code);
    int n = 0;
    @(negedge clk);
    while (!bus.char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", bus.char_ready, 1);
    bus.char_valid = 1'b1;
    bus.char_data  = code;
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle", bus.busy, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, bus.cur_x, x);
    check({tag, "_y"}, bus.cur_y, y);
  endtask

  // Every strobe must match the next queued write; an empty queue expects no strobe.
  always @(negedge clk) begin
    if (rst && bus.wea) begin
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("bus_write", {bus.addra, bus.dina}, mon_exp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.char_valid = 1'b0;
    bus.char_data  = 7'd0;
    bus.clear_req  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wea", bus.wea, 0);
    check("rst_addra", bus.addra, 0);
    check("rst_dina", bus.dina, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.char_ready, 1);
    check_cursor("rst_cur", 0, 0);
    rst = 1'b1;

    // Single put with an immediately-done peripheral; four back-to-back strobes
    done = 1'b1;
    model_put(7'h41);
    push_char(7'h41);
    n = 0;
    @(negedge clk);
    while (!bus.wea && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_addra", bus.addra, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("consec_wea", bus.wea, 1);
    end
    @(negedge clk);
    check("settle_wea", bus.wea, 0);
    wait_idle(200);
    check_cursor("put_a", 1, 0);

    // Peripheral not done: polling must not strobe or move the cursor
    done = 1'b0;
    model_put(7'h42);
    push_char(7'h42);
    repeat (40) @(negedge clk);
    check("poll_busy", bus.busy, 1);
    check_cursor("poll_hold", 1, 0);
    done = 1'b1;
    wait_idle(200);
    check_cursor("poll_done", 2, 0);

    // Newline moves to the next row without a bus access
    model_put(7'h48);
    push_char(7'h48);
    model_nl();
    push_char(7'h0A);
    model_put(7'h49);
    push_char(7'h49);
    wait_idle(500);
    check_cursor("newline", 1, 1);

    // Clear, then 81 characters wrap onto the second row
    model_clr();
    pulse_clear();
    wait_idle(200);
    check_cursor("clear", 0, 0);
    for (int i = 0; i < 81; i++) begin
      model_put(7'h61 + 7'(i % 26));
      push_char(7'h61 + 7'(i % 26));
    end
    wait_idle(2000);
    check_cursor("line_wrap", 1, 1);

    // Walk to the last cell, then one more put wraps the screen
    for (int i = 0; i < 28; i++) begin
      model_nl();
      push_char(7'h0A);
    end
    for (int i = 0; i < 79; i++) begin
      model_put(7'h2E);
      push_char(7'h2E);
    end
    wait_idle(3000);
    check_cursor("last_cell", 79, 29);
    model_put(7'h21);
    push_char(7'h21);
    wait_idle(200);
    check_cursor("screen_wrap", 0, 0);

    // Fill the FIFO while stuck polling, then clear mid-put
    done = 1'b0;
    model_put(7'h30);
    for (int i = 0; i < 9; i++) push_char(7'h30 + 7'(i));
    @(negedge clk);
    check("full_ready", bus.char_ready, 0);
    bus.char_valid = 1'b1;
    bus.char_data  = 7'h5A;
    repeat (3) @(negedge clk);
    bus.char_valid = 1'b0;
    model_clr();
    pulse_clear();
    for (int i = 1; i < 9; i++) model_put(7'h30 + 7'(i));
    done = 1'b1;
    wait_idle(2000);
    check_cursor("after_full", 8, 0);

    // Reset during SETTLE aborts the put and discards queued characters
    model_put(7'h52);
    push_char(7'h52);
    fork
      begin
        push_char(7'h53);
        push_char(7'h54);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!(bus.wea && bus.addra == 4'd0) && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("wr_cmd_seen", {bus.wea, bus.addra}, {1'b1, 4'h0});
      end
    join
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_wea", bus.wea, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.char_ready, 1);
    check_cursor("mid_rst_cur", 0, 0);
    mx = 0;
    my = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
